// File: rtl/cond_flag_unit_pkg.sv
// cond_flag_unit_pkg: shared definitions for the condition/flag unit.
//   - ARM condition-field encodings (COND_EQ .. COND_NV)
//   - bit positions of N, Z, C, V inside the flag nibble
//   - nzcv_t, the 4-bit {N,Z,C,V} flag type
package cond_flag_unit_pkg;

  typedef logic [3:0] nzcv_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// cond_eval: combinational ARM condition-field evaluator.
// Ports:
//   cond  in  4  instruction condition field
//   flags in  4  {N,Z,C,V}
//   pass  out 1  condition holds for these flags
module cond_eval
  import cond_flag_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  nzcv_t      flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      // 1111 is unpredictable; treat it as "never".
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: architectural NZCV register, per-instruction condition latch
// and write-strobe gating for the multicycle ARM datapath.
// Optional feature macro: COND_FLAG_SAVE_EN (adds SaveFlags/RestoreFlags and a
// shadow flag register).
// Ports:
//   clk          in   1  clock, rising edge
//   reset        in   1  asynchronous active-low reset
//   Cond         in   4  Instr[31:28]
//   ALUFlags     in   4  {N,Z,C,V} from the ALU
//   FlagW        in   2  [1] writes N,Z; [0] writes C,V
//   CondLatch    in   1  Decode strobe, captures the condition result
//   PCS          in   1  instruction writes the PC
//   NextPC       in   1  fetch-increment PC write
//   RegW, MemW   in   1  raw write requests
//   SaveFlags    in   1  (COND_FLAG_SAVE_EN) shadow <- Flags
//   RestoreFlags in   1  (COND_FLAG_SAVE_EN) Flags <- shadow
//   PCWrite, RegWrite, MemWrite  out 1  gated write enables
//   CondEx       out  1  latched condition pass
//   Flags        out  4  architectural NZCV
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondLatch,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
`ifdef COND_FLAG_SAVE_EN
  input  logic       SaveFlags,
  input  logic       RestoreFlags,
`endif
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  nzcv_t flags_q, flags_d;
  logic  cond_ex_q, cond_ex_d;
  logic  cond_pass;

  // Evaluated against the registered flags, so a same-edge flag write is not seen.
  cond_eval u_cond_eval (
    .cond  (Cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

`ifdef COND_FLAG_SAVE_EN
  nzcv_t shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (SaveFlags) begin
      shadow_d = flags_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= RESET_FLAGS;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  always_comb begin
    flags_d = flags_q;
    if (cond_ex_q && FlagW[1]) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (cond_ex_q && FlagW[0]) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
`ifdef COND_FLAG_SAVE_EN
    // Restore is ungated and overrides any ALU flag write on the same edge.
    if (RestoreFlags) begin
      flags_d = shadow_q;
    end
`endif
  end

  always_comb begin
    cond_ex_d = cond_ex_q;
    if (CondLatch) begin
      cond_ex_d = cond_pass;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q   <= RESET_FLAGS;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // NextPC is ungated so fetch proceeds straight out of reset.
  assign PCWrite  = NextPC | (PCS & cond_ex_q);
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;
  assign CondEx   = cond_ex_q;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Cond = 4'h0;
  logic [3:0] ALUFlags = 4'h0;
  logic [1:0] FlagW = 2'b00;
  logic       CondLatch = 1'b0;
  logic       PCS = 1'b0;
  logic       NextPC = 1'b0;
  logic       RegW = 1'b0;
  logic       MemW = 1'b0;
  logic       PCWrite, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cond_flag_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .Cond      (Cond),
    .ALUFlags  (ALUFlags),
    .FlagW     (FlagW),
    .CondLatch (CondLatch),
    .PCS       (PCS),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
`ifdef COND_FLAG_SAVE_EN
    .SaveFlags    (1'b0),
    .RestoreFlags (1'b0),
`endif
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .CondEx    (CondEx),
    .Flags     (Flags)
  );

  // Reference condition: pairs of codes test a base predicate, odd code inverts it.
  function automatic bit ref_eval(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0]) r = !r;
    return r;
  endfunction

  // Behavioural model of the architectural state.
  logic [3:0] m_flags = 4'b0000;
  bit         m_cex = 1'b0;

  always @(posedge clk or negedge reset) begin
    logic [3:0] old;
    if (!reset) begin
      m_flags = 4'b0000;
      m_cex   = 1'b0;
    end else begin
      old = m_flags;
      if (m_cex && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
      if (m_cex && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
      if (CondLatch) m_cex = ref_eval(Cond, old);
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    chk("model_flags", Flags, m_flags);
    chk("model_condex", {3'b0, CondEx}, {3'b0, m_cex});
    chk("model_pcwrite", {3'b0, PCWrite}, {3'b0, NextPC | (PCS & m_cex)});
    chk("model_regwrite", {3'b0, RegWrite}, {3'b0, RegW & m_cex});
    chk("model_memwrite", {3'b0, MemWrite}, {3'b0, MemW & m_cex});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic [3:0] c);
    CondLatch = 1'b1; Cond = c;
    tick();
    CondLatch = 1'b0;
  endtask

  task automatic write_flags(input logic [1:0] w, input logic [3:0] f);
    FlagW = w; ALUFlags = f;
    tick();
    FlagW = 2'b00;
  endtask

  task automatic set_flags(input logic [3:0] f);
    latch(4'hE);
    write_flags(2'b11, f);
  endtask

  localparam logic [3:0] SWEEP_FLAGS [4] = '{4'b1001, 4'b1000, 4'b0100, 4'b0001};
  localparam logic [3:0] SWEEP_CONDS [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h8, 4'h9};

  initial begin
    // Reset with raw requests asserted.
    NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1;
    @(negedge clk); #1;
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_condex", {3'b0, CondEx}, 4'd0);
    chk("rst_pcwrite", {3'b0, PCWrite}, 4'd1);
    chk("rst_regwrite", {3'b0, RegWrite}, 4'd0);
    chk("rst_memwrite", {3'b0, MemWrite}, 4'd0);
    tick();
    reset = 1'b1; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;

    // Flag write then EQ/NE.
    latch(4'hE);
    chk("al_condex", {3'b0, CondEx}, 4'd1);
    write_flags(2'b11, 4'b0100);
    chk("write_nzcv", Flags, 4'b0100);
    latch(4'h0);
    chk("eq_pass", {3'b0, CondEx}, 4'd1);
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; #1;
    chk("gate_regwrite_on", {3'b0, RegWrite}, 4'd1);
    chk("gate_pcwrite_on", {3'b0, PCWrite}, 4'd1);
    RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;
    latch(4'h1);
    chk("ne_fail", {3'b0, CondEx}, 4'd0);

    // Split writes.
    latch(4'hE);
    write_flags(2'b01, 4'b1011);
    chk("split_cv", Flags, 4'b0111);
    write_flags(2'b10, 4'b1000);
    chk("split_nz", Flags, 4'b1011);

    // Failed condition suppresses flag and write strobes.
    write_flags(2'b11, 4'b0000);
    latch(4'h0);
    chk("eq_fail", {3'b0, CondEx}, 4'd0);
    FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
    #1;
    chk("fail_regwrite", {3'b0, RegWrite}, 4'd0);
    chk("fail_memwrite", {3'b0, MemWrite}, 4'd0);
    chk("fail_pcwrite", {3'b0, PCWrite}, 4'd0);
    tick();
    chk("fail_flags_hold", Flags, 4'b0000);
    FlagW = 2'b00; RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;

    // Same-edge latch and write: latch sees the old flags.
    latch(4'hE);
    CondLatch = 1'b1; Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    CondLatch = 1'b0; FlagW = 2'b00;
    chk("same_edge_condex", {3'b0, CondEx}, 4'd0);
    chk("same_edge_flags", Flags, 4'b0100);

    // Never condition.
    set_flags(4'b0100);
    latch(4'hF);
    chk("nv_never", {3'b0, CondEx}, 4'd0);

    // Signed/unsigned compare sweep.
    foreach (SWEEP_FLAGS[i]) begin
      foreach (SWEEP_CONDS[j]) begin
        set_flags(SWEEP_FLAGS[i]);
        latch(SWEEP_CONDS[j]);
        chk("sweep_condex", {3'b0, CondEx}, {3'b0, ref_eval(SWEEP_CONDS[j], SWEEP_FLAGS[i])});
      end
    end
    set_flags(4'b1001);
    latch(4'hC);
    chk("gt_1001", {3'b0, CondEx}, 4'd1);
    set_flags(4'b0100);
    latch(4'hD);
    chk("le_0100", {3'b0, CondEx}, 4'd1);
    set_flags(4'b1000);
    latch(4'hA);
    chk("ge_1000", {3'b0, CondEx}, 4'd0);

    // Async reset mid-instruction.
    set_flags(4'b1111);
    latch(4'hE);
    chk("pre_rst_flags", Flags, 4'b1111);
    reset = 1'b0;
    #2;
    chk("async_rst_flags", Flags, 4'b0000);
    chk("async_rst_condex", {3'b0, CondEx}, 4'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
